// File: rtl/noun_loader_pkg.sv
// noun_loader_pkg: memory unit widths and function encodings shared by the loader and its bench
package noun_loader_pkg;
  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;
  localparam logic [1:0] MEM_FUNC_WRITE = 2'b01;
endpackage

// File: rtl/noun_loader.sv
// noun_loader: streams a tagged noun image into memory one write at a time, then launches traversal at base+entry_offset
module noun_loader
  import noun_loader_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] entry_offset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              mem_ready,
  output logic              mem_execute,
  output logic [1:0]        mem_func,
  output logic [ADDR_W-1:0] address1,
  output logic [ADDR_W-1:0] address2,
  output logic [DATA_W-1:0] write_data,
  output logic              trav_execute,
  output logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_count
);
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_ISSUE, S_WAIT, S_LAUNCH, S_ERROR} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] cap_data;
  logic cap_last, wait_first, start_ok, wr_done, at_top;
  assign start_ok = load_start && (state == S_IDLE || state == S_LAUNCH || state == S_ERROR);
  assign wr_done = state == S_WAIT && !wait_first && mem_ready;
  assign at_top = wr_addr == '1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_LAUNCH, S_ERROR: state_n = start_ok ? S_ACCEPT : state;
      S_ACCEPT: state_n = s_valid ? S_ISSUE : S_ACCEPT;
      S_ISSUE: state_n = mem_ready ? S_WAIT : S_ISSUE;
      S_WAIT: state_n = !wr_done ? S_WAIT : cap_last ? S_LAUNCH : at_top ? S_ERROR : S_ACCEPT;
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    s_ready = state == S_ACCEPT;
    mem_execute = state == S_ISSUE && mem_ready;
    mem_func = rst ? MEM_FUNC_WRITE : 2'b00;
    address1 = mem_execute ? wr_addr : '0;
    address2 = '0;
    write_data = mem_execute ? cap_data : '0;
    trav_execute = state == S_LAUNCH;
    done = state == S_LAUNCH;
    busy = state == S_ACCEPT || state == S_ISSUE || state == S_WAIT;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_addr <= '0;
      start_addr <= '0;
      word_count <= '0;
      cap_data <= '0;
      cap_last <= 1'b0;
      overflow <= 1'b0;
      wait_first <= 1'b0;
    end else begin
      wait_first <= state == S_ISSUE && mem_ready;
      if (start_ok) begin
        wr_addr <= base_addr;
        start_addr <= base_addr + entry_offset;
        word_count <= '0;
        overflow <= 1'b0;
      end
      if (state == S_ACCEPT && s_valid) begin
        cap_data <= s_data;
        cap_last <= s_last;
      end
      if (wr_done) begin
        word_count <= word_count + 1'b1;
        if (at_top && !cap_last) overflow <= 1'b1;
        else wr_addr <= wr_addr + 1'b1;
      end
    end
endmodule

// File: tb/tb_noun_loader.sv
// tb_noun_loader: directed scoreboard bench for noun_loader with a behavioural memory
module tb_noun_loader;
  import noun_loader_pkg::*;
  logic clk = 0, rst = 0, load_start = 0, s_valid = 0, s_last = 0, mem_ready = 1;
  logic [7:0] base_addr = 0, entry_offset = 0;
  logic [15:0] s_data = 0;
  logic s_ready, mem_execute, trav_execute, busy, done, overflow;
  logic [1:0] mem_func;
  logic [7:0] address1, address2, start_addr, word_count;
  logic [15:0] write_data;
  logic [15:0] mem [256];
  logic [25:0] exp_q[$], got_q[$];
  logic [7:0] exp_addr = 0;
  logic [15:0] img [8];
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  noun_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
    .entry_offset(entry_offset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .mem_ready(mem_ready), .mem_execute(mem_execute), .mem_func(mem_func),
    .address1(address1), .address2(address2), .write_data(write_data),
    .trav_execute(trav_execute), .start_addr(start_addr), .busy(busy), .done(done),
    .overflow(overflow), .word_count(word_count)
  );
  always @(posedge clk) if (mem_execute && mem_func == MEM_FUNC_WRITE) mem[address1] <= write_data;
  always @(negedge clk) if (mem_execute) got_q.push_back({mem_func, address1, write_data});
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start_load(logic [7:0] b, logic [7:0] o);
    base_addr = b;
    entry_offset = o;
    load_start = 1;
    exp_addr = b;
    step();
    load_start = 0;
  endtask
  task automatic send_word(logic [15:0] d, logic l, int gap);
    int n = 0;
    repeat (gap) step();
    s_valid = 1;
    s_data = d;
    s_last = l;
    exp_q.push_back({MEM_FUNC_WRITE, exp_addr, d});
    exp_addr++;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 200);
    chk("accept", s_ready, 1);
    step();
    s_valid = 0;
  endtask
  task automatic wait_end(string tag);
    int n = 0;
    while (!(done || overflow) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finish"}, done || overflow, 1);
  endtask
  task automatic cmp_strobes(string tag);
    chk({tag, "_nstrobe"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk({tag, "_strobe"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int seen;
    #12;
    chk("rst_outputs", {s_ready, mem_execute, mem_func, address1, address2, write_data, trav_execute,
                        start_addr, busy, done, overflow, word_count}, 0);
    rst = 1;
    step();
    chk("idle_busy", busy, 0);
    start_load(8'd0, 8'd1);
    chk("accept_busy", busy, 1);
    send_word(16'h1111, 0, 0);
    send_word(16'h2222, 0, 0);
    send_word(16'h3333, 1, 0);
    wait_end("basic");
    @(negedge clk);
    chk("basic_count", word_count, 3);
    chk("basic_trav", trav_execute, 1);
    chk("basic_done", done, 1);
    chk("basic_start", start_addr, 1);
    chk("basic_mem2", mem[2], 16'h3333);
    cmp_strobes("basic");
    start_load(8'd10, 8'd0);
    chk("relaunch_drop", {trav_execute, done}, 0);
    mem_ready = 0;
    send_word(16'hABCD, 1, 0);
    repeat (5) @(negedge clk);
    chk("stall_nostrobe", got_q.size(), 0);
    chk("stall_busy", busy, 1);
    mem_ready = 1;
    wait_end("stall");
    repeat (3) @(negedge clk);
    cmp_strobes("stall");
    chk("stall_count", word_count, 1);
    start_load(8'd20, 8'd3);
    for (int i = 0; i < 8; i++) begin
      img[i] = 16'($urandom);
      send_word(img[i], i == 7, int'($urandom_range(0, 7)));
    end
    wait_end("gaps");
    @(negedge clk);
    chk("gaps_count", word_count, 8);
    for (int i = 0; i < 8; i++) chk("gaps_mem", mem[20 + i], img[i]);
    cmp_strobes("gaps");
    start_load(8'd30, 8'd2);
    send_word(16'h0A0A, 0, 0);
    @(negedge clk);
    chk("busy_pulse", busy, 1);
    base_addr = 8'd100;
    entry_offset = 8'd0;
    load_start = 1;
    step();
    load_start = 0;
    send_word(16'h0B0B, 1, 0);
    wait_end("busyign");
    @(negedge clk);
    chk("busyign_count", word_count, 2);
    chk("busyign_start", start_addr, 32);
    cmp_strobes("busyign");
    start_load(8'd254, 8'd0);
    send_word(16'h5555, 0, 0);
    send_word(16'h6666, 0, 0);
    wait_end("ovf");
    @(negedge clk);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", word_count, 2);
    chk("ovf_status", {trav_execute, done, busy}, 0);
    s_valid = 1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen += int'(s_ready) + int'(trav_execute);
    end
    s_valid = 0;
    chk("ovf_stuck", seen, 0);
    cmp_strobes("ovf");
    start_load(8'd50, 8'd0);
    chk("ovf_clear", overflow, 0);
    send_word(16'h7777, 0, 0);
    step();
    mem_ready = 0;
    #3 rst = 0;
    #1;
    chk("async_rst", {s_ready, mem_execute, mem_func, address1, address2, write_data, trav_execute,
                      start_addr, busy, done, overflow, word_count}, 0);
    mem_ready = 1;
    repeat (2) step();
    rst = 1;
    step();
    cmp_strobes("rstwait");
    start_load(8'd60, 8'd5);
    send_word(16'h8888, 0, 1);
    send_word(16'h9999, 1, 2);
    wait_end("after_rst");
    @(negedge clk);
    chk("after_rst_count", word_count, 2);
    chk("after_rst_start", start_addr, 65);
    chk("after_rst_mem", mem[61], 16'h9999);
    cmp_strobes("after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/noun_loader.md
NOUN_LOADER -- requirements
Module: noun_loader

Interface
REQ-001 Parameter ADDR_W, default `memory_addr_width, is the memory address width.
REQ-002 Parameter DATA_W, default `memory_data_width, is the memory word width.
REQ-003 clk  in  1  single system clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 load_start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-006 base_addr  in  ADDR_W  first memory address written; sampled on load_start.
REQ-007 entry_offset  in  ADDR_W  offset of the root noun from base_addr; sampled on load_start.
REQ-008 s_valid  in  1  upstream word valid.
REQ-009 s_data  in  DATA_W  tagged memory word to store.
REQ-010 s_last  in  1  marks the final word of the image.
REQ-011 s_ready  out  1  loader accepts a word this cycle.
REQ-012 mem_ready  in  1  memory unit idle and able to accept a command.
REQ-013 mem_execute  out  1  one-cycle memory command strobe.
REQ-014 mem_func  out  2  memory function code; always the memory unit's write encoding from memory_unit.vh.
REQ-015 address1  out  ADDR_W  write address.
REQ-016 address2  out  ADDR_W  driven 0.
REQ-017 write_data  out  DATA_W  word being written.
REQ-018 trav_execute  out  1  level start for the traversal unit.
REQ-019 start_addr  out  ADDR_W  root address handed to the traversal unit.
REQ-020 busy, done, overflow  out  1 each  status flags.
REQ-021 word_count  out  ADDR_W  words written in the current load.

Function
REQ-022 States: IDLE, ACCEPT, ISSUE, WAIT, LAUNCH, ERROR.
REQ-023 IDLE: load_start latches base_addr into wr_addr, base_addr+entry_offset into start_addr, clears word_count, done and overflow, and moves to ACCEPT.
REQ-024 ACCEPT: s_ready=1; on s_valid&&s_ready, capture s_data and s_last and move to ISSUE; s_ready=0 in every other state.
REQ-025 ISSUE: when mem_ready=1, assert mem_execute for exactly one cycle with address1=wr_addr and write_data=captured word, then move to WAIT; while mem_ready=0, stay in ISSUE with mem_execute=0.
REQ-026 WAIT: ignore mem_ready in the first cycle; on the first later cycle with mem_ready=1, increment wr_addr and word_count, then move to LAUNCH if the captured last flag is set, else to ACCEPT.
REQ-027 Minimum throughput is one word per 4 cycles when memory responds in 1 cycle.
REQ-028 LAUNCH: trav_execute=1 and done=1, held until reset or the next accepted load_start, which drops both in the same cycle.
REQ-029 Overflow: if a word is accepted while wr_addr is all ones and not last, write it, then set overflow=1 and move to ERROR instead of wrapping; ERROR never asserts trav_execute.
REQ-030 load_start is ignored while busy=1; busy=1 in ACCEPT, ISSUE and WAIT.
REQ-031 A single-word image (s_last on the first word) is legal and reaches LAUNCH after one write.
REQ-032 start_addr arithmetic is modulo 2^ADDR_W; no overflow is flagged on it.

Reset
REQ-033 rst low forces state IDLE and drives every output to 0, including mem_execute, trav_execute, start_addr and word_count, independent of clk.
REQ-034 Reset during ISSUE or WAIT abandons the write without a further mem_execute strobe; the next load restarts at the new base_addr.

Structure
REQ-035 Width macros and memory function encodings come from memory_unit.vh; the state encoding is local to the module.
REQ-036 The module is flat, with no sub-modules; it drives the memory mux through its own select port and the traversal unit's execute/start_addr inputs.

Verification
REQ-037 base_addr=0, offset=1, image of 3 words ending in s_last -> writes at addresses 0,1,2; word_count=3; trav_execute=1 with start_addr=1.
REQ-038 mem_ready held low 5 cycles during ISSUE -> no strobe during the stall; exactly one mem_execute strobe after mem_ready rises.
REQ-039 s_valid gaps of 0-7 random cycles -> memory contents match the image; exactly one strobe per word.
REQ-040 base_addr=2^ADDR_W-2, 4-word image -> 2 writes, overflow=1, ERROR, trav_execute stays 0.
REQ-041 rst asserted in WAIT -> all outputs 0 asynchronously; a new load completes correctly.
REQ-042 load_start pulsed while busy -> ignored; word_count and base address unchanged.
